// File: rtl/xlnxstream_rx_2018_3.sv
// AXI4-Stream slave that captures one packet into a local buffer, reports its
// length, modular sum and overflow status, then serves a word-per-cycle read-out.
module xlnxstream_rx_2018_3 #(
  parameter int C_S_AXIS_TDATA_WIDTH  = 32,
  parameter int NUMBER_OF_INPUT_WORDS = 8
) (
  input  logic                                           S_AXIS_ACLK,
  input  logic                                           S_AXIS_ARESET,
  output logic                                           S_AXIS_TREADY,
  input  logic [C_S_AXIS_TDATA_WIDTH-1:0]                S_AXIS_TDATA,
  input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0]              S_AXIS_TSTRB,
  input  logic                                           S_AXIS_TLAST,
  input  logic                                           S_AXIS_TVALID,
  input  logic                                           RD_EN,
  output logic [C_S_AXIS_TDATA_WIDTH-1:0]                RD_DATA,
  output logic                                           PKT_VALID,
  output logic [$clog2(NUMBER_OF_INPUT_WORDS+1)-1:0]     PKT_LEN,
  output logic [C_S_AXIS_TDATA_WIDTH-1:0]                PKT_SUM,
  output logic                                           PKT_OVF
);

  localparam int W  = C_S_AXIS_TDATA_WIDTH;
  localparam int NB = C_S_AXIS_TDATA_WIDTH / 8;
  localparam int LW = $clog2(NUMBER_OF_INPUT_WORDS + 1);
  localparam int IW = (NUMBER_OF_INPUT_WORDS > 1) ? $clog2(NUMBER_OF_INPUT_WORDS) : 1;
  localparam logic [LW-1:0] LAST_IDX = LW'(NUMBER_OF_INPUT_WORDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_DROP = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  function automatic logic [W-1:0] mask_bytes(input logic [W-1:0] d, input logic [NB-1:0] strb);
    logic [W-1:0] m;
    m = '0;
    for (int i = 0; i < NB; i++) begin
      m[8*i +: 8] = strb[i] ? d[8*i +: 8] : 8'h00;
    end
    return m;
  endfunction

  state_t        state_q, state_d;
  logic [LW-1:0] wr_ptr_q, wr_ptr_d;
  logic [LW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] pkt_len_q, pkt_len_d;
  logic [W-1:0]  pkt_sum_q, pkt_sum_d;
  logic          pkt_ovf_q, pkt_ovf_d;
  logic          pkt_valid_q, pkt_valid_d;
  logic [W-1:0]  rd_data_q, rd_data_d;
  logic [W-1:0]  mem_q [NUMBER_OF_INPUT_WORDS];
  logic          mem_we;
  logic [W-1:0]  beat_masked;
  logic          beat_acc;

  assign S_AXIS_TREADY = (state_q == ST_RECV) || (state_q == ST_DROP);
  assign beat_acc      = S_AXIS_TVALID && S_AXIS_TREADY;
  assign beat_masked   = mask_bytes(S_AXIS_TDATA, S_AXIS_TSTRB);

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    pkt_len_d   = pkt_len_q;
    pkt_sum_d   = pkt_sum_q;
    pkt_ovf_d   = pkt_ovf_q;
    pkt_valid_d = pkt_valid_q;
    rd_data_d   = rd_data_q;
    mem_we      = 1'b0;
    unique case (state_q)
      ST_IDLE: state_d = ST_RECV;
      ST_RECV: begin
        if (beat_acc) begin
          mem_we    = 1'b1;
          wr_ptr_d  = wr_ptr_q + LW'(1);
          pkt_len_d = pkt_len_q + LW'(1);
          pkt_sum_d = pkt_sum_q + beat_masked;
          if (S_AXIS_TLAST) begin
            state_d     = ST_HOLD;
            pkt_valid_d = 1'b1;
          end else if (wr_ptr_q == LAST_IDX) begin
            state_d   = ST_DROP;
            pkt_ovf_d = 1'b1;
          end
        end
      end
      ST_DROP: begin
        if (beat_acc && S_AXIS_TLAST) begin
          state_d     = ST_HOLD;
          pkt_valid_d = 1'b1;
        end
      end
      ST_HOLD: begin
        if (RD_EN && (rd_ptr_q < pkt_len_q)) begin
          rd_data_d = mem_q[rd_ptr_q[IW-1:0]];
          rd_ptr_d  = rd_ptr_q + LW'(1);
          // Delivering the final word releases the buffer for the next packet.
          if ((rd_ptr_q + LW'(1)) == pkt_len_q) begin
            state_d     = ST_RECV;
            pkt_valid_d = 1'b0;
            pkt_len_d   = '0;
            pkt_sum_d   = '0;
            pkt_ovf_d   = 1'b0;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge S_AXIS_ACLK) begin
    if (S_AXIS_ARESET) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      pkt_len_q   <= '0;
      pkt_sum_q   <= '0;
      pkt_ovf_q   <= 1'b0;
      pkt_valid_q <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      pkt_len_q   <= pkt_len_d;
      pkt_sum_q   <= pkt_sum_d;
      pkt_ovf_q   <= pkt_ovf_d;
      pkt_valid_q <= pkt_valid_d;
      rd_data_q   <= rd_data_d;
    end
  end

  // Buffer storage carries no reset; only the pointers define its contents.
  always_ff @(posedge S_AXIS_ACLK) begin
    if (mem_we && !S_AXIS_ARESET) begin
      mem_q[wr_ptr_q[IW-1:0]] <= beat_masked;
    end
  end

  assign RD_DATA   = rd_data_q;
  assign PKT_VALID = pkt_valid_q;
  assign PKT_LEN   = pkt_len_q;
  assign PKT_SUM   = pkt_sum_q;
  assign PKT_OVF   = pkt_ovf_q;

endmodule
